// File: rtl/uart_frame_parser_if.sv
// Byte-stream bundle for the UART frame parser.
//   in_data/in_valid   : received bytes from the UART receiver (rxDone strobe)
//   out_data/out_valid : replayed payload bytes, valid/ready handshake
//   out_ready          : sink acceptance
//   out_last           : final payload byte marker, qualified by out_valid
// slave  = parser side, master = producer/sink side (testbench or system).
interface uart_frame_parser_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last
  );
endinterface

// File: rtl/uart_frame_parser.sv
// UART frame parser: extracts SYNC, LEN, payload, CSUM frames from a received
// byte strobe stream, buffers the payload, checks length and checksum, and
// replays good payloads on a valid/ready stream.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : uart_frame_parser_if.slave (input bytes + output stream)
//   frame_ok   : 1-cycle pulse, frame passed checks
//   frame_err  : 1-cycle pulse, frame dropped
//   err_code   : cause of last frame_err (0 bad LEN, 1 checksum, 2 timeout)
//   overrun    : 1-cycle pulse, byte dropped while draining
//   busy       : parser not idle
// All outputs are registered.
module uart_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_parser_if.slave  bus,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                overrun,
  output logic                busy
);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic            frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            overrun_q, overrun_d, busy_q, busy_d;
  logic [7:0]      buf_q [MAX_LEN];
  logic            buf_we;

  logic          len_bad, pay_last, csum_ok, tmo_hit, xfer;
  logic [IW-1:0] rd_nxt;

  assign len_bad  = (bus.in_data == 8'd0) || (bus.in_data > MAX_LEN_B);
  assign pay_last = (wr_idx_q == len_q - 1'b1);
  assign csum_ok  = (bus.in_data == sum_q);
  // The counter reaches TIMEOUT_CLKS on the edge after this cycle; an
  // in_valid in this same cycle takes priority in the case statements below.
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CLKS - 1));
  assign xfer     = out_valid_q & bus.out_ready;
  assign rd_nxt   = rd_idx_q + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.in_valid && bus.in_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN:     if (bus.in_valid) state_d = len_bad ? S_IDLE : S_PAYLOAD;
                 else if (tmo_hit) state_d = S_IDLE;
      S_PAYLOAD: if (bus.in_valid) begin
                   if (pay_last) state_d = S_CSUM;
                 end else if (tmo_hit) state_d = S_IDLE;
      S_CSUM:    if (bus.in_valid) state_d = csum_ok ? S_DRAIN : S_IDLE;
                 else if (tmo_hit) state_d = S_IDLE;
      S_DRAIN:   if (xfer && out_last_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;
    busy_d      = (state_d != S_IDLE);

    unique case (state_q)
      S_LEN: begin
        if (bus.in_valid) begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd0;
          end else begin
            len_d    = bus.in_data[IW-1:0];
            sum_d    = bus.in_data;
            wr_idx_d = '0;
          end
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_PAYLOAD: begin
        if (bus.in_valid) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + bus.in_data;
          wr_idx_d = wr_idx_q + 1'b1;
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_CSUM: begin
        if (bus.in_valid) begin
          if (csum_ok) begin
            // Preload the first byte so out_valid rises with frame_ok.
            frame_ok_d  = 1'b1;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
            out_data_d  = buf_q[0];
            out_last_d  = (len_q == IW'(1));
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_DRAIN: begin
        overrun_d = bus.in_valid;
        if (xfer) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            rd_idx_d   = rd_nxt;
            out_data_d = buf_q[rd_nxt[AW-1:0]];
            out_last_d = (rd_nxt == len_q - 1'b1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Payload storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_idx_q[AW-1:0]] <= bus.in_data;
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign frame_ok      = frame_ok_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;
endmodule
